// File: rtl/neighbor_min_scan.sv
// neighbor_min_scan: sequential four-neighbour minimum scan for the maze solver.
// Reads the N/E/S/W neighbour energies from the map RAM one per cycle,
// masks walled/off-board directions and keeps the strictly-smallest value
// (earlier direction wins ties). Fixed six-cycle latency from accepted start.
module neighbor_min_scan #(
    parameter int         MAP_W   = 16,
    parameter logic [6:0] UNREACH = 7'h7F
) (
    input  logic       m_clock,
    input  logic       p_reset,
    input  logic       start,
    input  logic [3:0] cur_x,
    input  logic [3:0] cur_y,
    input  logic [3:0] walls,
    output logic       map_rd,
    output logic [7:0] map_addr,
    input  logic [6:0] map_data,
    output logic       busy,
    output logic       done,
    output logic [6:0] best_ene,
    output logic [6:0] best_dir,
    output logic       no_path
);

    localparam logic [3:0] EDGE_C = 4'(MAP_W - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t     state_r;
    state_t     state_s;
    logic [1:0] idx_r;
    logic [3:0] x_r;
    logic [3:0] y_r;
    logic [3:0] open_r;
    logic [6:0] acc_ene_r;
    logic [6:0] acc_dir_r;

    logic       accept_s;
    logic [3:0] open_in_s;
    logic       cmp_en_s;
    logic [1:0] cmp_idx_s;
    logic [6:0] cand_s;
    logic [6:0] acc_ene_s;
    logic [6:0] acc_dir_s;

    // Open mask, slot order N,E,S,W in bits 0..3; walls arrive as {N,E,S,W}.
    function automatic logic [3:0] open_dirs(input logic [3:0] x, input logic [3:0] y,
                                             input logic [3:0] w);
        logic [3:0] o;
        o[0] = !w[3] && (y != EDGE_C);
        o[1] = !w[2] && (x != EDGE_C);
        o[2] = !w[1] && (y != 4'd0);
        o[3] = !w[0] && (x != 4'd0);
        return o;
    endfunction

    // RAM address {y,x} of the neighbour in slot k.
    function automatic logic [7:0] nbr_addr(input logic [3:0] x, input logic [3:0] y,
                                            input logic [1:0] k);
        logic [7:0] a;
        case (k)
            2'd0:    a = {y + 4'd1, x};
            2'd1:    a = {y, x + 4'd1};
            2'd2:    a = {y - 4'd1, x};
            2'd3:    a = {y, x - 4'd1};
            default: a = 8'd0;
        endcase
        return a;
    endfunction

    // One-hot direction code consumed by the downstream min selector.
    function automatic logic [6:0] dir_code(input logic [1:0] k);
        logic [6:0] d;
        case (k)
            2'd0:    d = 7'h01;
            2'd1:    d = 7'h02;
            2'd2:    d = 7'h04;
            2'd3:    d = 7'h08;
            default: d = 7'h00;
        endcase
        return d;
    endfunction

    // Next-state logic: fixed walk IDLE -> SCAN x4 -> FLUSH -> DONE -> IDLE.
    always_comb begin
        state_s  = state_r;
        accept_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_s  = ST_SCAN;
                    accept_s = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SCAN: begin
                if (idx_r == 2'd3) begin
                    state_s = ST_FLUSH;
                end else begin
                    state_s = ST_SCAN;
                end
            end
            ST_FLUSH: state_s = ST_DONE;
            ST_DONE:  state_s = ST_IDLE;
            default:  state_s = ST_IDLE;
        endcase
    end

    // Read strobe follows the current slot's open bit; no strobe outside SCAN.
    always_comb begin
        map_rd = 1'b0;
        if (state_r == ST_SCAN) begin
            map_rd = open_r[idx_r];
        end else begin
            map_rd = 1'b0;
        end
    end

    // Compare the previous slot's candidate (RAM data lags the strobe by one cycle).
    always_comb begin
        open_in_s = open_dirs(cur_x, cur_y, walls);
        cmp_en_s  = ((state_r == ST_SCAN) && (idx_r != 2'd0)) || (state_r == ST_FLUSH);
        cmp_idx_s = (state_r == ST_FLUSH) ? 2'd3 : (idx_r - 2'd1);
        cand_s    = open_r[cmp_idx_s] ? map_data : UNREACH;
        acc_ene_s = acc_ene_r;
        acc_dir_s = acc_dir_r;
        if (cmp_en_s && (cand_s < acc_ene_r)) begin
            acc_ene_s = cand_s;
            acc_dir_s = dir_code(cmp_idx_s);
        end else begin
            acc_ene_s = acc_ene_r;
            acc_dir_s = acc_dir_r;
        end
    end

    // State, slot index, latched cell context and accumulator.
    always_ff @(posedge m_clock or negedge p_reset) begin
        if (!p_reset) begin
            state_r   <= ST_IDLE;
            idx_r     <= 2'd0;
            x_r       <= 4'd0;
            y_r       <= 4'd0;
            open_r    <= 4'd0;
            acc_ene_r <= UNREACH;
            acc_dir_r <= 7'd0;
        end else begin
            state_r <= state_s;
            if (accept_s) begin
                idx_r     <= 2'd0;
                x_r       <= cur_x;
                y_r       <= cur_y;
                open_r    <= open_in_s;
                acc_ene_r <= UNREACH;
                acc_dir_r <= 7'd0;
            end else begin
                if (state_r == ST_SCAN) begin
                    idx_r <= idx_r + 2'd1;
                end
                acc_ene_r <= acc_ene_s;
                acc_dir_r <= acc_dir_s;
            end
        end
    end

    // Registered address: preload the next open slot's neighbour, else hold.
    always_ff @(posedge m_clock or negedge p_reset) begin
        if (!p_reset) begin
            map_addr <= 8'd0;
        end else if (accept_s) begin
            if (open_in_s[0]) begin
                map_addr <= nbr_addr(cur_x, cur_y, 2'd0);
            end
        end else if ((state_r == ST_SCAN) && (idx_r != 2'd3)) begin
            if (open_r[idx_r + 2'd1]) begin
                map_addr <= nbr_addr(x_r, y_r, idx_r + 2'd1);
            end
        end
    end

    // Registered status and result outputs; result loads with the final compare.
    always_ff @(posedge m_clock or negedge p_reset) begin
        if (!p_reset) begin
            busy     <= 1'b0;
            done     <= 1'b0;
            best_ene <= UNREACH;
            best_dir <= 7'd0;
            no_path  <= 1'b0;
        end else begin
            busy <= (state_s != ST_IDLE);
            done <= (state_s == ST_DONE);
            if (state_r == ST_FLUSH) begin
                best_ene <= acc_ene_s;
                best_dir <= acc_dir_s;
                no_path  <= (acc_dir_s == 7'd0);
            end
        end
    end

endmodule

// File: tb/tb_neighbor_min_scan.sv
// Self-checking bench for neighbor_min_scan: bench-side RAM model plus a
// coordinate-arithmetic reference of the four-neighbour minimum.
module tb_neighbor_min_scan;

    localparam int         MAP_W   = 16;
    localparam logic [6:0] UNREACH = 7'h7F;

    logic       m_clock = 1'b0;
    logic       p_reset = 1'b0;
    logic       start   = 1'b0;
    logic [3:0] cur_x   = 4'd0;
    logic [3:0] cur_y   = 4'd0;
    logic [3:0] walls   = 4'd0;
    logic       map_rd;
    logic [7:0] map_addr;
    logic [6:0] map_data = 7'd0;
    logic       busy;
    logic       done;
    logic [6:0] best_ene;
    logic [6:0] best_dir;
    logic       no_path;

    int n_checks = 0;
    int n_pass   = 0;

    logic [6:0] mem [256];
    logic [7:0] exp_addr;
    logic [6:0] exp_be;
    logic [6:0] exp_bd;
    logic       exp_np;
    logic       prev_rd;
    logic [7:0] prev_addr;

    neighbor_min_scan #(.MAP_W(MAP_W), .UNREACH(UNREACH)) dut (
        .m_clock (m_clock),
        .p_reset (p_reset),
        .start   (start),
        .cur_x   (cur_x),
        .cur_y   (cur_y),
        .walls   (walls),
        .map_rd  (map_rd),
        .map_addr(map_addr),
        .map_data(map_data),
        .busy    (busy),
        .done    (done),
        .best_ene(best_ene),
        .best_dir(best_dir),
        .no_path (no_path)
    );

    // Free-running clock.
    always #5 m_clock = ~m_clock;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic check_result();
        check_val("best_ene", 32'(best_ene), 32'(exp_be));
        check_val("best_dir", 32'(best_dir), 32'(exp_bd));
        check_val("no_path", 32'(no_path), 32'(exp_np));
    endtask

    task automatic check_reset_vals();
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_done", 32'(done), 32'd0);
        check_val("rst_map_rd", 32'(map_rd), 32'd0);
        check_val("rst_map_addr", 32'(map_addr), 32'd0);
        check_val("rst_best_ene", 32'(best_ene), 32'(UNREACH));
        check_val("rst_best_dir", 32'(best_dir), 32'd0);
        check_val("rst_no_path", 32'(no_path), 32'd0);
    endtask

    // RAM answers the strobe seen in the previous cycle; otherwise junk.
    task automatic drive_data();
        if (prev_rd) map_data = mem[prev_addr];
        else map_data = 7'($urandom_range(0, 127));
    endtask

    task automatic run_scan(input logic [3:0] x, input logic [3:0] y, input logic [3:0] w,
                            input bit ign, input int rst_at);
        int         nx;
        int         ny;
        bit         opn [4];
        logic [7:0] ad [4];
        logic [6:0] be;
        logic [6:0] bd;
        bit         erd;
        be = UNREACH;
        bd = 7'd0;
        for (int k = 0; k < 4; k++) begin
            nx = int'(x) + ((k == 1) ? 1 : 0) - ((k == 3) ? 1 : 0);
            ny = int'(y) + ((k == 0) ? 1 : 0) - ((k == 2) ? 1 : 0);
            opn[k] = !w[3-k] && nx >= 0 && nx < MAP_W && ny >= 0 && ny < MAP_W;
            ad[k] = 8'd0;
            if (opn[k]) begin
                ad[k] = 8'(ny * 16 + nx);
                if (mem[ad[k]] < be) begin
                    be = mem[ad[k]];
                    bd = 7'(1 << k);
                end
            end
        end
        start = 1'b1;
        cur_x = x;
        cur_y = y;
        walls = w;
        for (int c = 1; c <= 7; c++) begin
            @(posedge m_clock);
            #1;
            drive_data();
            start = (ign && (c == 2 || c == 6)) ? 1'b1 : 1'b0;
            cur_x = 4'($urandom);
            cur_y = 4'($urandom);
            walls = 4'($urandom);
            if (c == rst_at) begin
                p_reset = 1'b0;
                #1;
                check_reset_vals();
                @(negedge m_clock);
                p_reset   = 1'b1;
                exp_addr  = 8'd0;
                exp_be    = UNREACH;
                exp_bd    = 7'd0;
                exp_np    = 1'b0;
                for (int j = 0; j < 6; j++) begin
                    @(posedge m_clock);
                    #1;
                    map_data = 7'd0;
                    @(negedge m_clock);
                    check_val("post_rst_done", 32'(done), 32'd0);
                    check_val("post_rst_busy", 32'(busy), 32'd0);
                    check_val("post_rst_map_rd", 32'(map_rd), 32'd0);
                end
                prev_rd = 1'b0;
                return;
            end
            @(negedge m_clock);
            if (c == 6) begin
                exp_be = be;
                exp_bd = bd;
                exp_np = (bd == 7'd0);
            end
            erd = 1'b0;
            if (c <= 4) erd = opn[c-1];
            if (erd) exp_addr = ad[c-1];
            check_val("busy", 32'(busy), (c <= 6) ? 32'd1 : 32'd0);
            check_val("done", 32'(done), (c == 6) ? 32'd1 : 32'd0);
            check_val("map_rd", 32'(map_rd), 32'(erd));
            check_val("map_addr", 32'(map_addr), 32'(exp_addr));
            check_result();
            prev_rd   = map_rd;
            prev_addr = map_addr;
        end
    endtask

    function automatic logic [3:0] pick_coord();
        logic [3:0] v;
        case ($urandom_range(0, 3))
            0:       v = 4'd0;
            1:       v = 4'(MAP_W - 1);
            default: v = 4'($urandom_range(0, MAP_W - 1));
        endcase
        return v;
    endfunction

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 7'($urandom_range(0, 127));
        prev_rd   = 1'b0;
        prev_addr = 8'd0;
        exp_addr  = 8'd0;
        exp_be    = UNREACH;
        exp_bd    = 7'd0;
        exp_np    = 1'b0;

        // Reset state.
        repeat (2) @(posedge m_clock);
        @(negedge m_clock);
        check_reset_vals();
        p_reset = 1'b1;
        @(negedge m_clock);

        // Centre cell, distinct energies.
        mem[8'h65] = 7'd9; mem[8'h56] = 7'd4; mem[8'h45] = 7'd7; mem[8'h54] = 7'd12;
        run_scan(4'd5, 4'd5, 4'b0000, 1'b0, 0);
        check_val("tp_centre_ene", 32'(best_ene), 32'd4);
        check_val("tp_centre_dir", 32'(best_dir), 32'h02);

        // Four-way tie keeps N.
        mem[8'h65] = 7'd3; mem[8'h56] = 7'd3; mem[8'h45] = 7'd3; mem[8'h54] = 7'd3;
        run_scan(4'd5, 4'd5, 4'b0000, 1'b0, 0);
        check_val("tp_tie_dir", 32'(best_dir), 32'h01);

        // Corner: S and W off-board.
        mem[8'h10] = 7'd6; mem[8'h01] = 7'd2;
        run_scan(4'd0, 4'd0, 4'b0000, 1'b0, 0);
        check_val("tp_corner_ene", 32'(best_ene), 32'd2);

        // All walls.
        run_scan(4'd5, 4'd5, 4'b1111, 1'b0, 0);
        check_val("tp_walls_np", 32'(no_path), 32'd1);

        // All unreachable, ignored start pulses, then back-to-back accept.
        mem[8'h65] = UNREACH; mem[8'h56] = UNREACH; mem[8'h45] = UNREACH; mem[8'h54] = UNREACH;
        run_scan(4'd5, 4'd5, 4'b0000, 1'b1, 0);
        check_val("tp_unreach_dir", 32'(best_dir), 32'd0);
        run_scan(4'd7, 4'd7, 4'b0000, 1'b0, 0);

        // Reset mid-scan, then a fresh scan.
        mem[8'h65] = 7'd1; mem[8'h56] = 7'd2; mem[8'h45] = 7'd3; mem[8'h54] = 7'd4;
        run_scan(4'd5, 4'd5, 4'b0000, 1'b0, 3);
        mem[8'h65] = 7'd20; mem[8'h56] = 7'd30; mem[8'h45] = 7'd10; mem[8'h54] = 7'd40;
        run_scan(4'd5, 4'd5, 4'b0000, 1'b0, 0);
        check_val("tp_after_rst_ene", 32'(best_ene), 32'd10);

        // Randomized scans with edge-biased coordinates and tie-prone energies.
        for (int t = 0; t < 60; t++) begin
            for (int i = 0; i < 256; i++) begin
                if ($urandom_range(0, 3) == 0) mem[i] = UNREACH;
                else mem[i] = 7'($urandom_range(0, 15));
            end
            run_scan(pick_coord(), pick_coord(), 4'($urandom), ($urandom_range(0, 2) == 0), 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/neighbor_min_scan.md
# neighbor_min_scan

Sequential neighbour-scan stage for the maze solver: on each `start` it reads the step-map energies of the four neighbours of the current cell from the map RAM. It masks walled and off-board directions, reduces the four values to the minimum by repeated pairwise compare, and reports the winning energy with its direction code. It sits directly upstream of the two-input min selector and the move planner. Its 7-bit energy/direction outputs use the same encoding that stage consumes.

## Interface
- `MAP_W`, default 16: maze edge length in cells; coordinates run 0..MAP_W-1; must be ≤16.
- `UNREACH`, default 7'h7F: energy meaning "unreachable/unvisited"; also the initial best value.

Ports:
- `m_clock` in 1: single clock; all state changes on the rising edge.
- `p_reset` in 1: asynchronous, active-low reset.
- `start` in 1: begin scan; sampled only in IDLE.
- `cur_x` in 4: current cell x, latched on accepted `start`.
- `cur_y` in 4: current cell y, latched on accepted `start`.
- `walls` in 4: {N,E,S,W}; 1 = wall present; latched on accepted `start`.
- `map_rd` out 1: map RAM read strobe.
- `map_addr` out 8: map RAM address = {y[3:0], x[3:0]}.
- `map_data` in 7: RAM read data, valid exactly one cycle after `map_rd`.
- `busy` out 1: high from the cycle after an accepted `start` until `done` inclusive.
- `done` out 1: one-cycle result-valid pulse.
- `best_ene` out 7: minimum neighbour energy.
- `best_dir` out 7: N=7'h01, E=7'h02, S=7'h04, W=7'h08, 7'h00 = none.
- `no_path` out 1: no open neighbour has energy < UNREACH.

## Operation
- States: IDLE, SCAN (idx 0..3 = N,E,S,W), FLUSH, DONE.
- IDLE -> SCAN idx0 on `start`=1. `start` is ignored in every other state.
- Neighbour coordinates:
  - N = (x, y+1)
  - E = (x+1, y)
  - S = (x, y-1)
  - W = (x-1, y)
- A direction is open when its wall bit is 0 and the neighbour is on the board. Off-board means: y=MAP_W-1 for N, x=MAP_W-1 for E, y=0 for S, x=0 for W.
- SCAN idx k, direction open: assert `map_rd` and drive `map_addr` with the neighbour address.
- SCAN idx k, direction closed: `map_rd`=0, `map_addr` holds its previous value, and the candidate for that slot is forced to UNREACH.
- Accumulator: `acc_ene` starts at UNREACH and `acc_dir` at 0 on `start` acceptance. Each candidate is compared one cycle after its slot. A strictly smaller candidate replaces both fields, so ties keep the earlier direction (priority N>E>S>W).
- Arithmetic is 7-bit unsigned compare only; there is no add and no wrap.
- SCAN idx3 -> FLUSH: compare the idx3 candidate.
- FLUSH -> DONE: `done`=1, `best_ene`/`best_dir` update from the accumulator, and `no_path` = (acc_dir==0).
- DONE -> IDLE.
- `best_ene`, `best_dir` and `no_path` hold until the next DONE.

## Timing
- Fixed latency regardless of walls. With `start` sampled at edge E0:
  - SCAN idx0..3 in cycles 1..4.
  - FLUSH in cycle 5.
  - DONE (`done`=1) in cycle 6.
  - IDLE in cycle 7.
- A new `start` is accepted in cycle 7 at the earliest. A `start` held high through DONE is not accepted until IDLE.
- `map_rd` is combinational from state and open mask. `map_addr` is registered; `map_data` is sampled one cycle after the strobe.
- Reset (async, any state): state=IDLE, `busy`=0, `done`=0, `map_rd`=0, `map_addr`=0, `best_ene`=UNREACH, `best_dir`=0, `no_path`=0, accumulator cleared. No `done` is produced for an interrupted scan.
- A `map_data` cycle arriving after a mid-scan reset is ignored.

## Test plan
- Centre cell (5,5), walls=0; RAM N=9, E=4, S=7, W=12 -> `map_rd` cycles 1-4 at addrs 0x65, 0x56, 0x45, 0x54; `done` in cycle 6 with `best_ene`=4, `best_dir`=7'h02, `no_path`=0.
- Tie: (5,5), N=3, E=3, S=3, W=3 -> `best_dir`=7'h01, `best_ene`=3.
- Corner (0,0), walls=0; N=6, E=2 -> no reads in cycles 3-4 (S/W off-board); `best_ene`=2, `best_dir`=7'h02.
- Walls=4'b1111 at (5,5) -> no `map_rd` asserted; `done` still in cycle 6; `best_ene`=7'h7F, `best_dir`=0, `no_path`=1.
- All open neighbours read 7'h7F -> `no_path`=1, `best_dir`=0. `start` pulses in cycles 2 and 6 are ignored; a `start` in cycle 7 is accepted.
- `p_reset` low during cycle 3 of a scan -> outputs at reset values immediately; no `done`; the next `start` scans normally with a fresh accumulator.
